// File: rtl/add_chk_pkg.sv
// Shared types and helpers for the adder-result scoreboard: triple layout,
// checker FSM states and the reference sum.
package add_chk_pkg;

  localparam int OP_W  = 3;
  localparam int RES_W = OP_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]  x;
    logic [OP_W-1:0]  y;
    logic [RES_W-1:0] z;
  } add_triple_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } chk_state_e;

  // Full-width reference sum; the carry bit is kept so a truncated z fails.
  function automatic logic [RES_W-1:0] exp_sum(input logic [OP_W-1:0] x,
                                               input logic [OP_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/add_chk_fifo.sv
// Small synchronous FIFO of adder triples; clr flushes and beats push/pop.
// Push is ignored when full and pop is ignored when empty.
module add_chk_fifo
  import add_chk_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = add_triple_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/add_result_scoreboard.sv
// Checks buffered {x, y, z} adder triples one per cycle, counting passes and
// failures, summing z and capturing the first mismatch.
module add_result_scoreboard
  import add_chk_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int ACC_W       = 12,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   chk_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_x,
  input  logic [OP_W-1:0]        in_y,
  input  logic [RES_W-1:0]       in_z,
  output logic                   chk_valid,
  output logic                   chk_pass,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [ACC_W-1:0]       z_sum,
  output logic                   err_flag,
  output logic [OP_W-1:0]        err_x,
  output logic [OP_W-1:0]        err_y,
  output logic [RES_W-1:0]       err_z,
  output logic                   halted,
  output chk_state_e             state_dbg,
  output logic [$clog2(DEPTH):0] fifo_level
);

  // Handshake: a triple transfers on a rising clk when in_valid && in_ready;
  // in_ready depends only on the registered FIFO level, never on in_valid.

  chk_state_e  state, state_nxt;
  add_triple_t wr_t, rd_t;
  logic        fifo_full, fifo_empty;
  logic        push, pop, halt_now, cur_pass;

  assign wr_t     = '{x: in_x, y: in_y, z: in_z};
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !clr;
  assign halt_now = STOP_ON_ERR && chk_valid && !chk_pass;
  assign pop      = (state == CHECK) && !fifo_empty && !halt_now && !clr;
  assign cur_pass = (rd_t.z == exp_sum(rd_t.x, rd_t.y));
  assign halted    = (state == HALT);
  assign state_dbg = state;

  add_chk_fifo #(.DEPTH(DEPTH), .T(add_triple_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .wdata (wr_t),
    .pop   (pop),
    .rdata (rd_t),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (chk_en) state_nxt = CHECK;
      CHECK:   if (halt_now) state_nxt = HALT;
               else if (!chk_en) state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Check result and all statistics land on the same edge as chk_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      z_sum     <= '0;
      err_flag  <= 1'b0;
      err_x     <= '0;
      err_y     <= '0;
      err_z     <= '0;
    end else begin
      chk_valid <= pop;
      chk_pass  <= pop && cur_pass;
      if (pop) begin
        z_sum <= z_sum + ACC_W'(rd_t.z);
        if (cur_pass) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_x    <= rd_t.x;
            err_y    <= rd_t.y;
            err_z    <= rd_t.z;
          end
        end
      end
    end
  end

endmodule
